// File: rtl/writeback_pkg.sv
// writeback_pkg
//   Shared types and widths for the writeback stage.
//   WB_DATA_W / WB_ADDR_W : default result width and register index width
//   wb_src_e              : which result path an entry came from
//   wb_entry_t            : one pending register-file write {rd, data}
package writeback_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_stage_skid.sv
// wb_skid_reg
//   One-entry holding register in front of the writeback arbiter.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : upstream offers in_entry
//   in_ready   : entry accepted when in_valid && in_ready
//   in_entry   : offered {rd, data}
//   pop        : arbiter consumes the held entry this cycle
//   full       : an entry is held
//   entry      : the held {rd, data}
//
// Handshake: a transfer happens on the rising edge where in_valid && in_ready.
// in_ready = !full || pop, so a popped entry can be replaced in the same cycle
// and an uncontended source sustains one entry per cycle.
module wb_skid_reg
   import writeback_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      in_valid,
   output logic      in_ready,
   input  wb_entry_t in_entry,
   input  logic      pop,
   output logic      full,
   output wb_entry_t entry
);

   logic accept;

   assign in_ready = !full || pop;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         full  <= 1'b0;
         entry <= '0;
      end else if (accept) begin
         full  <= 1'b1;
         entry <= in_entry;
      end else if (pop) begin
         full  <= 1'b0;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Arbitrates ALU and load results onto the single register-file write port
//   and tracks outstanding loads per register.
//   clk, reset                      : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake and payload
//   mem_valid/mem_ready/mem_rd/mem_data : load result handshake and payload
//   issue_valid, issue_rd           : a load to issue_rd is issued this cycle
//   query_rs1, query_rs2            : source registers being issued
//   rs1_pending, rs2_pending        : combinational scoreboard lookups
//   write_enable, rd, reg_data_in   : registered register-file write port
//
// Handshake (both sources): a result transfers on the rising edge where
// valid && ready; ready = !full || granted. Grant depends only on skid state,
// so ready never depends on valid. Upstream holds valid and payload stable
// until the transfer.
module writeback_stage
   import writeback_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_W,
   parameter int ADDR_WIDTH = WB_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] query_rs1,
   input  logic [ADDR_WIDTH-1:0] query_rs2,
   output logic                  rs1_pending,
   output logic                  rs2_pending,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0] reg_data_in
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   wb_entry_t alu_in, mem_in, alu_head, mem_head, grant_entry;
   logic      alu_full, mem_full, alu_pop, mem_pop, grant_any;
   wb_src_e   grant_src, last_grant, out_src;

   logic [NUM_REGS-1:0] pending, pending_next;

   assign alu_in = '{rd: alu_rd, data: alu_data};
   assign mem_in = '{rd: mem_rd, data: mem_data};

   wb_skid_reg u_alu_skid (
      .clk      (clk),
      .reset    (reset),
      .in_valid (alu_valid),
      .in_ready (alu_ready),
      .in_entry (alu_in),
      .pop      (alu_pop),
      .full     (alu_full),
      .entry    (alu_head)
   );

   wb_skid_reg u_mem_skid (
      .clk      (clk),
      .reset    (reset),
      .in_valid (mem_valid),
      .in_ready (mem_ready),
      .in_entry (mem_in),
      .pop      (mem_pop),
      .full     (mem_full),
      .entry    (mem_head)
   );

   // Under contention the source that lost last time wins; last_grant only
   // moves on contention, so the two sources strictly alternate.
   always_comb begin
      grant_any   = alu_full || mem_full;
      grant_src   = SRC_ALU;
      if (alu_full && mem_full) begin
         grant_src = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end else if (mem_full) begin
         grant_src = SRC_MEM;
      end
      alu_pop     = grant_any && (grant_src == SRC_ALU);
      mem_pop     = grant_any && (grant_src == SRC_MEM);
      grant_entry = (grant_src == SRC_MEM) ? mem_head : alu_head;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= SRC_ALU;
      end else if (alu_full && mem_full) begin
         last_grant <= grant_src;
      end
   end

   // Writes to x0 still take a grant slot and load rd/data, but never strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_enable <= 1'b0;
         rd           <= '0;
         reg_data_in  <= '0;
         out_src      <= SRC_ALU;
      end else if (grant_any) begin
         write_enable <= (grant_entry.rd != '0);
         rd           <= grant_entry.rd;
         reg_data_in  <= grant_entry.data;
         out_src      <= grant_src;
      end else begin
         write_enable <= 1'b0;
      end
   end

   // A load's bit clears on the edge the register file captures its data.
   // The set is applied after the clear so a same-cycle reissue wins.
   always_comb begin
      pending_next = pending;
      if (write_enable && (out_src == SRC_MEM)) begin
         pending_next[rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
         pending_next[issue_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   assign rs1_pending = pending[query_rs1];
   assign rs2_pending = pending[query_rs2];

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Directed scenarios for writeback_stage. Inputs are driven 1 time unit
//   after a rising edge; outputs are observed at the same point, i.e. after
//   the previous edge has settled and before the next one.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        issue_valid;
   logic [4:0]  issue_rd, query_rs1, query_rs2;
   logic        rs1_pending, rs2_pending;
   logic        write_enable;
   logic [4:0]  rd;
   logic [31:0] reg_data_in;

   int tests_run;
   int tests_failed;

   writeback_stage dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .query_rs1    (query_rs1),
      .query_rs2    (query_rs2),
      .rs1_pending  (rs1_pending),
      .rs2_pending  (rs2_pending),
      .write_enable (write_enable),
      .rd           (rd),
      .reg_data_in  (reg_data_in)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      mem_valid   = 1'b0;
      mem_rd      = '0;
      mem_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      query_rs1   = '0;
      query_rs2   = '0;
      repeat (2) step();
      reset = 1'b0;
      #1;
   endtask

   // driver helpers
   task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = r;
      alu_data  = d;
   endtask

   task automatic drive_mem(input logic v, input logic [4:0] r, input logic [31:0] d);
      mem_valid = v;
      mem_rd    = r;
      mem_data  = d;
   endtask

   task automatic test_reset();
      do_reset();
      query_rs1 = 5'd9;
      query_rs2 = 5'd31;
      #1;
      tests_run++;
      if (write_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_we: got %b expected 0", write_enable);
      end
      tests_run++;
      if (rd !== 5'd0 || reg_data_in !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_out: got rd=%0d data=%h expected rd=0 data=0", rd, reg_data_in);
      end
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
      end
      tests_run++;
      if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pending: got rs1=%b rs2=%b expected 0 0", rs1_pending, rs2_pending);
      end
   endtask

   task automatic test_single_alu();
      do_reset();
      drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
      tests_run++;
      if (alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL alu_ready_offer: got %b expected 1", alu_ready);
      end
      step();  // edge 1: accepted
      drive_alu(1'b0, 5'd0, 32'h0);
      tests_run++;
      if (write_enable !== 1'b0 || alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL alu_held: got we=%b ready=%b expected we=0 ready=1", write_enable, alu_ready);
      end
      step();  // edge 2: output registers loaded
      tests_run++;
      if (write_enable !== 1'b1 || rd !== 5'd5 || reg_data_in !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL alu_write: got we=%b rd=%0d data=%h expected we=1 rd=5 data=deadbeef",
                  write_enable, rd, reg_data_in);
      end
      step();
      tests_run++;
      if (write_enable !== 1'b0 || rd !== 5'd5 || reg_data_in !== 32'hDEADBEEF || alu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL alu_after: got we=%b rd=%0d data=%h ready=%b expected we=0 rd=5 data=deadbeef ready=1",
                  write_enable, rd, reg_data_in, alu_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  exp_rd   [3];
      logic [31:0] exp_data [3];
      exp_rd   = '{5'd1, 5'd2, 5'd3};
      exp_data = '{32'h100, 32'h200, 32'h300};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_alu(1'b1, exp_rd[i], exp_data[i]);
         tests_run++;
         if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready[%0d]: got %b expected 1", i, alu_ready);
         end
         step();
         if (i > 0) begin
            tests_run++;
            if (write_enable !== 1'b1 || rd !== exp_rd[i-1] || reg_data_in !== exp_data[i-1]) begin
               tests_failed++;
               $display("FAIL b2b_write[%0d]: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h",
                        i - 1, write_enable, rd, reg_data_in, exp_rd[i-1], exp_data[i-1]);
            end
         end
      end
      drive_alu(1'b0, 5'd0, 32'h0);
      step();
      tests_run++;
      if (write_enable !== 1'b1 || rd !== 5'd3 || reg_data_in !== 32'h300) begin
         tests_failed++;
         $display("FAIL b2b_write[2]: got we=%b rd=%0d data=%h expected we=1 rd=3 data=300",
                  write_enable, rd, reg_data_in);
      end
      step();
      tests_run++;
      if (write_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: got we=%b expected 0", write_enable);
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int round = 0; round < 2; round++) begin
         drive_alu(1'b1, 5'd3, 32'h11);
         drive_mem(1'b1, 5'd4, 32'h22);
         step();  // both accepted
         drive_alu(1'b0, 5'd0, 32'h0);
         drive_mem(1'b0, 5'd0, 32'h0);
         #1;
         // round 0: MEM wins the first contention; round 1: ALU wins.
         tests_run++;
         if (alu_ready !== (round == 1) || mem_ready !== (round == 0)) begin
            tests_failed++;
            $display("FAIL cont_ready[%0d]: got alu=%b mem=%b expected alu=%b mem=%b",
                     round, alu_ready, mem_ready, round == 1, round == 0);
         end
         step();
         tests_run++;
         if (write_enable !== 1'b1 || rd !== (round == 0 ? 5'd4 : 5'd3)
             || reg_data_in !== (round == 0 ? 32'h22 : 32'h11)) begin
            tests_failed++;
            $display("FAIL cont_first[%0d]: got we=%b rd=%0d data=%h expected rd=%0d",
                     round, write_enable, rd, reg_data_in, round == 0 ? 4 : 3);
         end
         step();
         tests_run++;
         if (write_enable !== 1'b1 || rd !== (round == 0 ? 5'd3 : 5'd4)
             || reg_data_in !== (round == 0 ? 32'h11 : 32'h22)) begin
            tests_failed++;
            $display("FAIL cont_second[%0d]: got we=%b rd=%0d data=%h expected rd=%0d",
                     round, write_enable, rd, reg_data_in, round == 0 ? 3 : 4);
         end
         step();
         tests_run++;
         if (write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL cont_idle[%0d]: got we=%b expected 0", round, write_enable);
         end
      end
   endtask

   task automatic test_x0();
      do_reset();
      drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_we[%0d]: got %b expected 0", i, write_enable);
         end
         if (i == 1) begin
            tests_run++;
            if (rd !== 5'd0 || reg_data_in !== 32'hFFFFFFFF) begin
               tests_failed++;
               $display("FAIL x0_slot: got rd=%0d data=%h expected rd=0 data=ffffffff", rd, reg_data_in);
            end
         end
         step();
      end
   endtask

   task automatic test_load_tracking();
      do_reset();
      query_rs1   = 5'd7;
      query_rs2   = 5'd7;
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      #1;
      tests_run++;
      if (rs1_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL ld_before_issue: got %b expected 0", rs1_pending);
      end
      step();
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      #1;
      tests_run++;
      if (rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL ld_set: got rs1=%b rs2=%b expected 1 1", rs1_pending, rs2_pending);
      end
      // ALU write to r7 must not clear the load bit.
      drive_alu(1'b1, 5'd7, 32'h77);
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      step();
      step();
      tests_run++;
      if (rs1_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL ld_alu_noclear: got %b expected 1", rs1_pending);
      end
      drive_mem(1'b1, 5'd7, 32'h1234);
      step();  // accepted
      drive_mem(1'b0, 5'd0, 32'h0);
      step();  // output registers hold the load
      tests_run++;
      if (write_enable !== 1'b1 || rd !== 5'd7 || reg_data_in !== 32'h1234 || rs1_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL ld_write: got we=%b rd=%0d data=%h pend=%b expected we=1 rd=7 data=1234 pend=1",
                  write_enable, rd, reg_data_in, rs1_pending);
      end
      step();  // register file captures; bit clears
      tests_run++;
      if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL ld_clear: got rs1=%b rs2=%b expected 0 0", rs1_pending, rs2_pending);
      end
   endtask

   task automatic test_set_clear_same_cycle();
      do_reset();
      query_rs1 = 5'd7;
      drive_mem(1'b1, 5'd7, 32'h55);
      step();
      drive_mem(1'b0, 5'd0, 32'h0);
      step();  // MEM r7 write in the output registers: clears on next edge
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      tests_run++;
      if (write_enable !== 1'b1 || rd !== 5'd7) begin
         tests_failed++;
         $display("FAIL sc_write: got we=%b rd=%0d expected we=1 rd=7", write_enable, rd);
      end
      step();
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      #1;
      tests_run++;
      if (rs1_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL sc_set_wins: got %b expected 1", rs1_pending);
      end
      step();
      tests_run++;
      if (rs1_pending !== 1'b1) begin
         tests_failed++;
         $display("FAIL sc_stays: got %b expected 1", rs1_pending);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      query_rs1   = 5'd9;
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      step();
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      drive_alu(1'b1, 5'd10, 32'hA);
      drive_mem(1'b1, 5'd11, 32'hB);
      step();  // both skids full
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_mem(1'b0, 5'd0, 32'h0);
      reset = 1'b1;
      #1;
      tests_run++;
      if (rs1_pending !== 1'b1 || write_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL rm_before: got pend=%b we=%b expected pend=1 we=0", rs1_pending, write_enable);
      end
      step();  // reset edge
      reset = 1'b0;
      #1;
      tests_run++;
      if (write_enable !== 1'b0 || rs1_pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL rm_after: got we=%b pend=%b expected we=0 pend=0", write_enable, rs1_pending);
      end
      tests_run++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rm_ready: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++;
         if (write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL rm_no_write[%0d]: got we=%b rd=%0d expected we=0", i, write_enable, rd);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_single_alu();
      test_back_to_back();
      test_contention();
      test_x0();
      test_load_tracking();
      test_set_clear_same_cycle();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
